// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Load-use hazard detection and pipeline stall/flush control for a
//   classic 5-stage pipeline. A load in EX whose destination feeds a source
//   of the instruction in ID inserts STALL_CYCLES bubbles into ID/EX. A taken
//   branch resolved in EX flushes IF/ID and ID/EX and abandons any stall.
//
// Parameters
//   STALL_CYCLES  bubbles per load-use hazard (1..7)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk, arst_n          clock, asynchronous active-low reset
//   rs1_id, rs2_id       ID-stage source registers
//   use_rs1_id/_rs2_id   ID instruction actually reads rs1/rs2
//   rd_ex, mem_read_ex   EX-stage destination and load flag
//   branch_taken_ex      taken branch/jump resolved in EX
//   pc_write, if_id_write          register enables
//   id_ex_bubble                   insert NOP into ID/EX
//   if_id_flush, id_ex_flush       clear IF/ID, ID/EX
//   stall_cnt, flush_cnt           saturating event counters
module hazard_stall_unit #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN,
    STALL
  } state_e;

  // The hazard cycle itself is the first bubble, so the STALL state only
  // covers the remaining STALL_CYCLES-1 cycles.
  localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             hazard;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  always_comb begin
    hazard = mem_read_ex && (rd_ex != 5'd0) &&
             ((use_rs1_id && (rs1_id == rd_ex)) ||
              (use_rs2_id && (rs2_id == rd_ex)));
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; a taken branch overrides everything.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (branch_taken_ex) begin
      state_d = RUN;
      rem_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard && (STALL_CYCLES > 1)) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end
        end
        STALL: begin
          rem_d = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Output logic (Mealy on hazard/branch). Reset forces every control low
  // combinationally so the pipeline is frozen while arst_n is held.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (arst_n) begin
      if (branch_taken_ex) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if ((state_q == STALL) || hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (branch_taken_ex && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit. Three instances share stimulus:
//   u1 : STALL_CYCLES=1, CNT_W=16
//   u3 : STALL_CYCLES=3, CNT_W=16
//   u4 : STALL_CYCLES=3, CNT_W=4  (counter saturation)
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, mem_read_ex, branch_taken_ex;

  logic        pc1, ifw1, bub1, iff1, ief1;
  logic [15:0] sc1, fc1;
  logic        pc3, ifw3, bub3, iff3, ief3;
  logic [15:0] sc3, fc3;
  logic        pc4, ifw4, bub4, iff4, ief4;
  logic [3:0]  sc4, fc4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc1), .if_id_write(ifw1), .id_ex_bubble(bub1),
    .if_id_flush(iff1), .id_ex_flush(ief1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_stall_unit #(.STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc3), .if_id_write(ifw3), .id_ex_bubble(bub3),
    .if_id_flush(iff3), .id_ex_flush(ief3), .stall_cnt(sc3), .flush_cnt(fc3));

  hazard_stall_unit #(.STALL_CYCLES(3), .CNT_W(4)) u4 (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc4), .if_id_write(ifw4), .id_ex_bubble(bub4),
    .if_id_flush(iff4), .id_ex_flush(ief4), .stall_cnt(sc4), .flush_cnt(fc4));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic set_idle();
    rs1_id = 5'd1; rs2_id = 5'd2; rd_ex = 5'd3;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
  endtask

  task automatic set_hazard();
    rd_ex = 5'd5; mem_read_ex = 1'b1; rs1_id = 5'd5; use_rs1_id = 1'b1;
    rs2_id = 5'd2; use_rs2_id = 1'b0; branch_taken_ex = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point for combinational outputs in the current cycle.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    arst_n = 1'b0;
    tick();
    mid();
    arst_n = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    arst_n = 1'b0;
    #2;
    // Reset state
    check("rst_pc1",  32'(pc1),  32'd0);
    check("rst_ifw1", 32'(ifw1), 32'd0);
    check("rst_bub3", 32'(bub3), 32'd0);
    check("rst_sc3",  32'(sc3),  32'd0);
    check("rst_fc3",  32'(fc3),  32'd0);
    mid();
    arst_n = 1'b1;
    tick();

    // Single load-use hazard: u1 one bubble, u3 three bubbles
    set_hazard();
    mid();
    check("h1_pc1",  32'(pc1),  32'd0);
    check("h1_ifw1", 32'(ifw1), 32'd0);
    check("h1_bub1", 32'(bub1), 32'd1);
    check("h1_bub3", 32'(bub3), 32'd1);
    tick();
    set_idle();
    mid();
    check("h1_next_pc1",  32'(pc1),  32'd1);
    check("h1_next_bub1", 32'(bub1), 32'd0);
    check("h1_sc1",       32'(sc1),  32'd1);
    check("h3_c1_bub3",   32'(bub3), 32'd1);
    check("h3_c1_pc3",    32'(pc3),  32'd0);
    tick();
    mid();
    check("h3_c2_bub3", 32'(bub3), 32'd1);
    tick();
    mid();
    check("h3_c3_bub3", 32'(bub3), 32'd0);
    check("h3_c3_pc3",  32'(pc3),  32'd1);
    check("h3_sc3",     32'(sc3),  32'd3);
    check("h3_sc1",     32'(sc1),  32'd1);

    // Branch on second stall cycle abandons the stall
    do_reset();
    set_hazard();
    tick();
    set_idle();
    branch_taken_ex = 1'b1;
    mid();
    check("br_pc3",  32'(pc3),  32'd1);
    check("br_ifw3", 32'(ifw3), 32'd1);
    check("br_iff3", 32'(iff3), 32'd1);
    check("br_ief3", 32'(ief3), 32'd1);
    check("br_bub3", 32'(bub3), 32'd0);
    tick();
    set_idle();
    mid();
    check("br_after_bub3", 32'(bub3), 32'd0);
    check("br_after_pc3",  32'(pc3),  32'd1);
    check("br_sc3",        32'(sc3),  32'd1);
    check("br_fc3",        32'(fc3),  32'd1);

    // Hazard and branch together: branch only, no stall counted
    do_reset();
    set_hazard();
    branch_taken_ex = 1'b1;
    mid();
    check("hb_iff3", 32'(iff3), 32'd1);
    check("hb_bub3", 32'(bub3), 32'd0);
    check("hb_bub1", 32'(bub1), 32'd0);
    tick();
    // x0 destination never stalls
    set_idle();
    rd_ex = 5'd0; mem_read_ex = 1'b1; rs1_id = 5'd0; use_rs1_id = 1'b1;
    mid();
    check("hb_sc3",   32'(sc3),  32'd0);
    check("hb_fc3",   32'(fc3),  32'd1);
    check("x0_bub3",  32'(bub3), 32'd0);
    check("x0_pc3",   32'(pc3),  32'd1);
    tick();
    // rs2 path hazard
    set_idle();
    rd_ex = 5'd7; mem_read_ex = 1'b1; rs2_id = 5'd7; use_rs2_id = 1'b1;
    mid();
    check("rs2_bub1", 32'(bub1), 32'd1);
    // Matching register but not a load
    mem_read_ex = 1'b0;
    #1;
    check("noload_bub1", 32'(bub1), 32'd0);
    // Matching load but operand not used
    mem_read_ex = 1'b1; use_rs2_id = 1'b0;
    #1;
    check("nouse_bub1", 32'(bub1), 32'd0);
    tick();
    set_idle();
    mid();
    check("x0_sc3", 32'(sc3), 32'd0);

    // Continuous hazards: back-to-back stalls and saturation on u4
    do_reset();
    set_hazard();
    for (int i = 0; i < 20; i++) begin
      mid();
      if (i == 3) begin
        check("b2b_bub3", 32'(bub3), 32'd1);
        check("b2b_pc3",  32'(pc3),  32'd0);
      end
      tick();
    end
    // Cycle 20 is the last STALL cycle of a sequence; bubble ignores inputs.
    set_idle();
    mid();
    check("sat_bub4", 32'(bub4), 32'd1);
    check("sat_sc4",  32'(sc4),  32'd15);
    check("sat_sc3",  32'(sc3),  32'd20);
    // Asynchronous reset mid-stall
    arst_n = 1'b0;
    #1;
    check("arst_bub4", 32'(bub4), 32'd0);
    check("arst_pc4",  32'(pc4),  32'd0);
    check("arst_ifw4", 32'(ifw4), 32'd0);
    check("arst_iff4", 32'(iff4), 32'd0);
    check("arst_sc4",  32'(sc4),  32'd0);
    check("arst_fc4",  32'(fc4),  32'd0);
    tick();
    mid();
    arst_n = 1'b1;
    tick();
    mid();
    check("post_rst_pc4",  32'(pc4),  32'd1);
    check("post_rst_bub4", 32'(bub4), 32'd0);
    tick();
    // New hazard after reset starts from RUN: a full 3-cycle stall
    set_hazard();
    tick();
    set_idle();
    mid();
    check("post_rst_stall_bub4", 32'(bub4), 32'd1);
    tick();
    tick();
    mid();
    check("post_rst_done_bub4", 32'(bub4), 32'd0);
    check("post_rst_sc4",       32'(sc4),  32'd3);

    // Flush counter saturation
    branch_taken_ex = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    set_idle();
    mid();
    check("sat_fc4", 32'(fc4), 32'd15);
    check("sat_fc3", 32'(fc3), 32'd18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter STALL_CYCLES, default 1: number of bubble cycles inserted per load-use hazard, legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs1_id  input  5  source register 1 of the instruction in ID.
REQ-006 rs2_id  input  5  source register 2 of the instruction in ID.
REQ-007 use_rs1_id  input  1  the ID instruction reads rs1.
REQ-008 use_rs2_id  input  1  the ID instruction reads rs2.
REQ-009 rd_ex  input  5  destination register of the instruction in EX.
REQ-010 mem_read_ex  input  1  the EX instruction is a load.
REQ-011 branch_taken_ex  input  1  a taken branch or jump was resolved in EX this cycle.
REQ-012 pc_write  output  1  PC register enable.
REQ-013 if_id_write  output  1  IF/ID register enable.
REQ-014 id_ex_bubble  output  1  load a NOP into ID/EX instead of the ID instruction.
REQ-015 if_id_flush  output  1  clear IF/ID to a NOP.
REQ-016 id_ex_flush  output  1  clear ID/EX to a NOP.
REQ-017 stall_cnt  output  CNT_W  total bubble cycles inserted, saturating.
REQ-018 flush_cnt  output  CNT_W  total taken-branch flush events, saturating.

Function
REQ-019 A load-use hazard SHALL be detected combinationally as: mem_read_ex=1, rd_ex!=0, and either (use_rs1_id and rs1_id==rd_ex) or (use_rs2_id and rs2_id==rd_ex).
REQ-020 The FSM SHALL have two states, RUN and STALL, plus a 3-bit remaining-cycle counter rem.
REQ-021 In RUN with no hazard and no branch: pc_write=1, if_id_write=1, and all other control outputs are 0.
REQ-022 In RUN with a hazard and no branch: pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle (Mealy).
- If STALL_CYCLES>1: next state STALL, rem=STALL_CYCLES-1.
- Otherwise: remain in RUN.
REQ-023 In STALL: pc_write=0, if_id_write=0, id_ex_bubble=1, independent of the hazard inputs.
- rem decrements each cycle.
- When rem==1, the next state is RUN.
REQ-024 On branch_taken_ex=1, in either state: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0.
- Next state RUN, rem=0.
- Any pending stall is abandoned.
REQ-025 A branch and a hazard in the same cycle SHALL be handled as a branch only; no stall is counted.
REQ-026 stall_cnt SHALL increment by 1 every cycle in which id_ex_bubble=1, and hold at all-ones.
REQ-027 flush_cnt SHALL increment by 1 every cycle in which branch_taken_ex=1, and hold at all-ones.
REQ-028 Consecutive hazards SHALL be serviced back-to-back: a hazard detected in the first RUN cycle after STALL starts a new stall sequence.
REQ-029 Hazards involving x0 SHALL never stall, regardless of mem_read_ex.

Reset
REQ-030 While arst_n=0, the following SHALL hold regardless of other inputs:
- state=RUN, rem=0, stall_cnt=0, flush_cnt=0;
- pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0, id_ex_flush=0.
REQ-031 Reset assertion SHALL take effect immediately (asynchronously), including mid-stall. After release, the first rising edge SHALL operate from RUN.

Verification
REQ-032 STALL_CYCLES=1; rd_ex=5, mem_read_ex=1, rs1_id=5, use_rs1_id=1 for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (no hazard) pc_write=1; stall_cnt=1.
REQ-033 STALL_CYCLES=3; same hazard for 1 cycle, then inputs idle -> bubble high for exactly 3 cycles, then RUN; stall_cnt=3.
REQ-034 STALL_CYCLES=3; hazard, then branch_taken_ex=1 on the second stall cycle -> that cycle both flushes=1, pc_write=1, bubble=0; following cycle RUN with no bubble; stall_cnt=1, flush_cnt=1.
REQ-035 Hazard and branch in the same cycle; and separately rd_ex=0 with mem_read_ex=1, rs1_id=0 -> first case: flushes only, stall_cnt unchanged; second case: no stall.
REQ-036 CNT_W=4; drive 20 hazard cycles -> stall_cnt saturates at 15. Assert arst_n=0 mid-stall -> all outputs and counters 0 immediately; after release, state is RUN.
